// File: rtl/subtrator_serial_4b_pkg.sv
// ----------------------------------------------------------------------------
// subtrator_serial_4b_pkg
// Shared definitions for the bit-serial subtractor:
//   - DEFAULT_WIDTH : default operand/result width
//   - state_t       : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
// ----------------------------------------------------------------------------
package subtrator_serial_4b_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : subtrator_serial_4b_pkg

// File: rtl/subtrator_completo.sv
// ----------------------------------------------------------------------------
// subtrator_completo
// Combinational one-bit full subtractor: a - b - bin.
// Ports:
//   a, b, bin : input bits (minuend, subtrahend, borrow-in)
//   d         : difference bit
//   bout      : borrow-out
// ----------------------------------------------------------------------------
module subtrator_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : subtrator_completo

// File: rtl/subtrator_serial_4b.sv
// ----------------------------------------------------------------------------
// subtrator_serial_4b
// Bit-serial subtractor: D = A - B - bin, one bit per clock, LSB first.
// Operands are latched when start is accepted in IDLE; WIDTH shift cycles
// follow, then a one-cycle DONE with done=1 and d/bout valid. d and bout
// hold until the next operation completes.
//
// Optional feature macro: SUBTRATOR_OVF_EN adds the registered signed
// overflow output ovf, valid and held with the same timing as d.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : minuend / subtrahend (WIDTH bits), sampled with start
//   bin   : borrow-in, sampled with start
//   busy  : high during SHIFT and DONE
//   done  : one-cycle pulse, d/bout valid
//   d     : registered difference (WIDTH bits)
//   bout  : registered borrow-out
//   ovf   : registered signed overflow (SUBTRATOR_OVF_EN only)
// ----------------------------------------------------------------------------
module subtrator_serial_4b
    import subtrator_serial_4b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUBTRATOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sa_r, sa_s;
    logic [WIDTH-1:0] sb_r, sb_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic             br_r, br_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] d_r, d_s;
    logic             bout_r, bout_s;
    logic             fs_d_s, fs_bout_s;
`ifdef SUBTRATOR_OVF_EN
    logic             am_r, am_s;
    logic             bm_r, bm_s;
    logic             ovf_r, ovf_s;
`endif

    subtrator_completo u_fs (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .bin  (br_r),
        .d    (fs_d_s),
        .bout (fs_bout_s)
    );

    // Next-state and next-output logic for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_s = state_r;
        sa_s    = sa_r;
        sb_s    = sb_r;
        res_s   = res_r;
        br_s    = br_r;
        count_s = count_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        d_s     = d_r;
        bout_s  = bout_r;
`ifdef SUBTRATOR_OVF_EN
        am_s    = am_r;
        bm_s    = bm_r;
        ovf_s   = ovf_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sa_s    = a;
                    sb_s    = b;
                    br_s    = bin;
                    count_s = '0;
                    busy_s  = 1'b1;
                    state_s = ST_SHIFT;
`ifdef SUBTRATOR_OVF_EN
                    am_s    = a[WIDTH-1];
                    bm_s    = b[WIDTH-1];
`endif
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                sa_s    = sa_r >> 1;
                sb_s    = sb_r >> 1;
                br_s    = fs_bout_s;
                res_s   = {fs_d_s, res_r[WIDTH-1:1]};
                count_s = count_r + CNT_W'(1);
                if (count_r == CNT_LAST) begin
                    // Publish the finished result on the last shift edge so
                    // d/bout are valid in the same cycle that done is high.
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    d_s     = res_s;
                    bout_s  = fs_bout_s;
`ifdef SUBTRATOR_OVF_EN
                    ovf_s   = (am_r != bm_r) && (fs_d_s != am_r);
`endif
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sa_r    <= '0;
            sb_r    <= '0;
            res_r   <= '0;
            br_r    <= 1'b0;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            d_r     <= '0;
            bout_r  <= 1'b0;
`ifdef SUBTRATOR_OVF_EN
            am_r    <= 1'b0;
            bm_r    <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            sa_r    <= sa_s;
            sb_r    <= sb_s;
            res_r   <= res_s;
            br_r    <= br_s;
            count_r <= count_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            d_r     <= d_s;
            bout_r  <= bout_s;
`ifdef SUBTRATOR_OVF_EN
            am_r    <= am_s;
            bm_r    <= bm_s;
            ovf_r   <= ovf_s;
`endif
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign bout = bout_r;
`ifdef SUBTRATOR_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule : subtrator_serial_4b
